// File: rtl/tlc_sensor_conditioner.sv
// Vehicle-sensor front end for the traffic light controller: per-street synchronizer,
// debouncer, arrival pulse and a request latch cleared by the controller's green feedback.
module tlc_sensor_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter bit LATCH_EN   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic ga,
  input  logic gb,
  output logic Sa,
  output logic Sb,
  output logic arrive_a,
  output logic arrive_b
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0] raw_w;
  logic [1:0] serve_w;
  logic [1:0] req_out_w;
  logic [1:0] arrive_w;

  assign raw_w   = {raw_b, raw_a};
  assign serve_w = {gb, ga};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          s1_q, s2_q;
      logic          deb_q, deb_d;
      logic          req_q, req_d;
      logic          arr_q;
      logic          rise_w;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s2_q == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_d = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      assign rise_w = ~deb_q & deb_d;

      // A new arrival beats a simultaneous serve; green only clears once the car has left.
      always_comb begin
        req_d = req_q;
        if (!LATCH_EN) begin
          req_d = 1'b0;
        end else if (rise_w) begin
          req_d = 1'b1;
        end else if (serve_w[gi] && !deb_q) begin
          req_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          deb_q <= 1'b0;
          cnt_q <= '0;
          req_q <= 1'b0;
          arr_q <= 1'b0;
        end else begin
          s1_q  <= raw_w[gi];
          s2_q  <= s1_q;
          deb_q <= deb_d;
          cnt_q <= cnt_d;
          req_q <= req_d;
          arr_q <= rise_w;
        end
      end

      assign req_out_w[gi] = deb_q | req_q;
      assign arrive_w[gi]  = arr_q;
    end
  endgenerate

  assign Sa       = req_out_w[0];
  assign Sb       = req_out_w[1];
  assign arrive_a = arrive_w[0];
  assign arrive_b = arrive_w[1];

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Bench for tlc_sensor_conditioner: directed scenarios plus random traffic, checked against
// a sliding-window model of debounce, arrival and request latching.
module tb_tlc_sensor_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_a = 1'b0, raw_b = 1'b0, ga = 1'b0, gb = 1'b0;
  logic sa_l, sb_l, aa_l, ab_l;
  logic sa_n, sb_n, aa_n, ab_n;

  int checks = 0;
  int errors = 0;

  // Model: raw history (index 0 = sample at latest edge), debounced level, request, arrival.
  bit hist[2][DEB+2];
  bit mdeb[2];
  bit mreq[2];
  bit marr[2];

  always #5 clk = ~clk;

  tlc_sensor_conditioner #(.DEB_CYCLES(DEB), .LATCH_EN(1'b1)) dut_l (
    .clk(clk), .reset_n(reset_n), .raw_a(raw_a), .raw_b(raw_b), .ga(ga), .gb(gb),
    .Sa(sa_l), .Sb(sb_l), .arrive_a(aa_l), .arrive_b(ab_l)
  );

  tlc_sensor_conditioner #(.DEB_CYCLES(DEB), .LATCH_EN(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .raw_a(raw_a), .raw_b(raw_b), .ga(ga), .gb(gb),
    .Sa(sa_n), .Sb(sb_n), .arrive_a(aa_n), .arrive_b(ab_n)
  );

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DEB + 2; i++) hist[c][i] = 1'b0;
      mdeb[c] = 1'b0;
      mreq[c] = 1'b0;
      marr[c] = 1'b0;
    end
  endfunction

  // Debounced level flips when the synchronized input (raw two edges back) has
  // disagreed with it on each of the last DEB edges.
  function automatic void model_edge();
    bit raw[2];
    bit serve[2];
    bit all_diff;
    bit old;
    raw[0] = raw_a;  raw[1] = raw_b;
    serve[0] = ga;   serve[1] = gb;
    for (int c = 0; c < 2; c++) begin
      for (int i = DEB + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = raw[c];
      all_diff = 1'b1;
      for (int j = 2; j < DEB + 2; j++) if (hist[c][j] == mdeb[c]) all_diff = 1'b0;
      old = mdeb[c];
      marr[c] = 1'b0;
      if (all_diff) mdeb[c] = ~mdeb[c];
      if (all_diff && mdeb[c]) begin
        marr[c] = 1'b1;
        mreq[c] = 1'b1;
      end else if (serve[c] && !old) begin
        mreq[c] = 1'b0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("sa_latch", sa_l, mdeb[0] | mreq[0]);
    check("sb_latch", sb_l, mdeb[1] | mreq[1]);
    check("arrive_a_latch", aa_l, marr[0]);
    check("arrive_b_latch", ab_l, marr[1]);
    check("sa_nolatch", sa_n, mdeb[0]);
    check("sb_nolatch", sb_n, mdeb[1]);
    check("arrive_a_nolatch", aa_n, marr[0]);
    check("arrive_b_nolatch", ab_n, marr[1]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sa"}, sa_l, 1'b0);
    check({tag, "_sb"}, sb_l, 1'b0);
    check({tag, "_aa"}, aa_l, 1'b0);
    check({tag, "_ab"}, ab_l, 1'b0);
    check({tag, "_sb_n"}, sb_n, 1'b0);
  endtask

  // Inputs change at the falling edge, model advances on the rising edge,
  // outputs compared at the next falling edge.
  task automatic step(input logic ra, input logic rb, input logic a, input logic b);
    raw_a = ra; raw_b = rb; ga = a; gb = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    $display("step raw_a=%0b raw_b=%0b ga=%0b gb=%0b -> Sa=%0b Sb=%0b arr_a=%0b arr_b=%0b",
             ra, rb, a, b, sa_l, sb_l, aa_l, ab_l);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    int arrivals;
    int highs;
    model_reset();
    #1;
    check_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // Clean rise on A: Sa and arrive after the sixth edge (edge index 5).
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_sa_before", sa_l, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_sa_rise", sa_l, 1'b1);
    check("t1_arrive_hi", aa_l, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_arrive_lo", aa_l, 1'b0);
    check("t1_sa_hold", sa_l, 1'b1);

    // A leaves with no green: request stays latched, then green serves it.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_latched", sa_l, 1'b1);
    check("t3_nolatch_low", sa_n, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_served", sa_l, 1'b0);

    // Bounce on B: 3 high, 1 low, then held; one arrival, 5 edges after final rise.
    arrivals = 0;
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b1, 1'b0, 1'b0); arrivals += int'(ab_l); end
    step(1'b0, 1'b0, 1'b0, 1'b0); arrivals += int'(ab_l);
    for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1, 1'b0, 1'b0); arrivals += int'(ab_l); end
    check("t2_sb_before", sb_l, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0); arrivals += int'(ab_l);
    check("t2_sb_rise", sb_l, 1'b1);
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, 1'b0, 1'b0); arrivals += int'(ab_l); end
    check("t2_one_arrival", logic'(arrivals == 1), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_sb_cleared", sb_l, 1'b0);

    // Collision on A: green held while the arrival debounces; set wins.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_set_wins", sa_l, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_held_with_car", sa_l, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_deb_low_req", sa_l, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_cleared", sa_l, 1'b0);

    // Reset with req_b set and the counter mid-way, raw_b still high afterwards.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    raw_b = 1'b1;
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_sb_before", sb_l, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_sb_rise", sb_l, 1'b1);

    // Non-latching instance: a 6-cycle pulse on B gives 6 high cycles; greens ignored.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    highs = 0;
    for (int i = 0; i < 6; i++) begin step(1'b0, 1'b1, logic'(i % 2), 1'b1); highs += int'(sb_n); end
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0, 1'b1, logic'(i % 2)); highs += int'(sb_n); end
    check("t6_six_high", logic'(highs == 6), 1'b1);

    // Random traffic, with one reset dropped in the middle.
    for (int i = 0; i < 400; i++) begin
      logic ra, rb, a, b;
      ra = ($urandom_range(0, 4) == 0) ? ~raw_a : raw_a;
      rb = ($urandom_range(0, 4) == 0) ? ~raw_b : raw_b;
      a  = ($urandom_range(0, 3) == 0) ? ~ga : ga;
      b  = ($urandom_range(0, 3) == 0) ? ~gb : gb;
      if (i == 200) pulse_reset();
      step(ra, rb, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
